// File: rtl/eth_gmii_pkg.sv
// Shared GMII receive definitions: deframer state encoding, preamble/SFD
// byte values and the CRC-32 constants used for FCS checking.
package eth_gmii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DISCARD  = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bytes held back so the 4-byte FCS can be stripped once the frame ends.
  localparam int DLY_LEN = 5;

endpackage

// File: rtl/gmii_rx_deframer_if.sv
// Bundle of the GMII receive inputs and the AXI-Stream style outputs of the
// deframer. The stream has no tready: a beat is transferred on every cycle
// tvalid is high, and the consumer must always accept it. tuser is only
// meaningful on the beat with tlast set.
interface gmii_rx_deframer_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       error_bad_frame;
  logic       error_bad_fcs;

  // Source side: drives the PHY bytes, observes the stream.
  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  error_bad_frame, error_bad_fcs
  );

  // Deframer side.
  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output error_bad_frame, error_bad_fcs
  );
endinterface

// File: rtl/gmii_rx_deframer_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB first, no final
// inversion). Purely combinational.
module crc32_byte
  import eth_gmii_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [31:0] crc_i,
  output logic [31:0] crc_o
);

  // Bit-serial shift of the eight data bits, unrolled into logic.
  always_comb begin
    crc_o = crc_i;
    for (int b = 0; b < 8; b++) begin
      if (crc_o[0] ^ data_i[b]) begin
        crc_o = (crc_o >> 1) ^ CRC_POLY;
      end else begin
        crc_o = crc_o >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, holds the last four bytes back
// so the FCS can be removed, and flags rx_er, oversize and runt frames.
// Optional FCS checking is compiled in with the GMII_RX_FCS_CHECK_EN macro.
module gmii_rx_deframer
  import eth_gmii_pkg::*;
#(
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       error_bad_frame,
  output logic       error_bad_fcs,
  output rx_state_e  dbg_state_o
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_LEN);
  localparam logic [CW-1:0] HOLD_C = CW'(DLY_LEN);

  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DLY_LEN-1:0][7:0]   dly_q, dly_d;
  logic                      err_q, err_d;
  logic [7:0]                tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic                      tuser_q, tuser_d;
  logic                      bad_frame_q, bad_frame_d;
  logic                      fcs_bad;

`ifdef GMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;
  logic        bad_fcs_q, bad_fcs_d;

  crc32_byte u_crc (
    .data_i (gmii_rxd),
    .crc_i  (crc_q),
    .crc_o  (crc_next)
  );

  // The register runs over data and FCS; a good frame leaves the residue.
  assign fcs_bad       = (crc_q != CRC_RESIDUE);
  assign error_bad_fcs = bad_fcs_q;
`else
  assign fcs_bad       = 1'b0;
  assign error_bad_fcs = 1'b0;
`endif

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign error_bad_frame = bad_frame_q;
  assign dbg_state_o     = state_q;

  // State, byte counter, delay line, sticky error and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      dly_q       <= '0;
      err_q       <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      bad_frame_q <= 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
      crc_q       <= CRC_INIT;
      bad_fcs_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dly_q       <= dly_d;
      err_q       <= err_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      bad_frame_q <= bad_frame_d;
`ifdef GMII_RX_FCS_CHECK_EN
      crc_q       <= crc_d;
      bad_fcs_q   <= bad_fcs_d;
`endif
    end
  end

  // Next-state logic: frame delineation, delay-line shifting and beat emission.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dly_d       = dly_q;
    err_d       = err_q;
    tdata_d     = '0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    bad_frame_d = 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
    crc_d       = crc_q;
    bad_fcs_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (gmii_rxd == SFD) begin
          state_d = ST_PAYLOAD;
          count_d = '0;
          err_d   = 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
          crc_d   = CRC_INIT;
`endif
        end else if (gmii_rxd == PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end

      ST_PAYLOAD: begin
        if (gmii_rx_dv) begin
          if (count_q == MAX_C) begin
            // One byte too many: close the frame on the oldest held byte.
            tdata_d     = dly_q[DLY_LEN-1];
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tuser_d     = 1'b1;
            bad_frame_d = 1'b1;
            state_d     = ST_DISCARD;
          end else begin
            if (count_q >= HOLD_C) begin
              tdata_d  = dly_q[DLY_LEN-1];
              tvalid_d = 1'b1;
            end
            dly_d   = {dly_q[DLY_LEN-2:0], gmii_rxd};
            count_d = count_q + CW'(1);
            err_d   = err_q | gmii_rx_er;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_d   = crc_next;
`endif
          end
        end else begin
          state_d = ST_IDLE;
          if (count_q >= HOLD_C) begin
            // The four youngest held bytes are the FCS and are dropped.
            tdata_d     = dly_q[DLY_LEN-1];
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tuser_d     = err_q | fcs_bad;
            bad_frame_d = err_q;
`ifdef GMII_RX_FCS_CHECK_EN
            bad_fcs_d   = fcs_bad;
`endif
          end else begin
            bad_frame_d = 1'b1;
          end
        end
      end

      ST_DISCARD: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518: maximum post-SFD byte count per frame, FCS included.
REQ-002 SHALL have port clk, input, 1: single clock, the MAC-side GMII RX clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port gmii_rxd, input, 8: receive byte.
REQ-005 SHALL have port gmii_rx_dv, input, 1: receive data valid.
REQ-006 SHALL have port gmii_rx_er, input, 1: receive error.
REQ-007 SHALL have port m_axis_tdata, output, 8: payload byte.
REQ-008 SHALL have port m_axis_tvalid, output, 1: beat valid; no tready, so the stream never stalls.
REQ-009 SHALL have port m_axis_tlast, output, 1: last beat of the frame.
REQ-010 SHALL have port m_axis_tuser, output, 1: frame bad; meaningful only with tlast.
REQ-011 SHALL have port error_bad_frame, output, 1: one-cycle pulse on rx_er, oversize or runt.
REQ-012 SHALL have port error_bad_fcs, output, 1: one-cycle pulse on FCS mismatch.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, PAYLOAD and DISCARD.
REQ-014 IDLE: stays while dv=0; on dv=1 with rxd=0x55 -> PREAMBLE; on dv=1 with rxd=0xD5 -> PAYLOAD; on any other dv=1 byte -> DISCARD.
REQ-015 PREAMBLE: 0x55 -> stay; 0xD5 -> PAYLOAD; other byte -> DISCARD; dv=0 -> IDLE.
REQ-016 DISCARD: no outputs; leaves to IDLE on the first cycle dv=0 is sampled.
REQ-017 PAYLOAD: bytes after the SFD enter a 5-byte delay line and the byte count increments.
REQ-018 Post-SFD byte k SHALL be emitted with tvalid=1, tlast=0 one cycle after byte k+5 is sampled.
REQ-019 Frame end (dv=0 sampled in PAYLOAD) with count≥5: the oldest held byte SHALL be emitted next cycle with tlast=1; the 4 youngest bytes (FCS) are stripped; -> IDLE.
REQ-020 Frame end with count<5 (runt): no beats emitted, error_bad_frame pulses, -> IDLE.
REQ-021 rx_er sampled at any point during PAYLOAD SHALL latch a sticky error; at frame end tuser=1 and error_bad_frame pulses.
REQ-022 When count would exceed MAX_LEN: the oldest held byte SHALL be emitted with tlast=1, tuser=1; error_bad_frame pulses; -> DISCARD.
REQ-023 tuser SHALL equal the OR of the sticky rx_er error, oversize and (if compiled) FCS mismatch.
REQ-024 Back-to-back frames: dv=0 for a single cycle between frames SHALL be sufficient; the IDLE state accepts a preamble on the next cycle.
REQ-025 Error pulses SHALL be coincident with the tlast beat they describe; a runt's pulse comes one cycle after the dv=0 sample.

Reset
REQ-026 On rst: state=IDLE; count, delay line and sticky flags cleared; all outputs 0 on the next cycle.
REQ-027 Reset mid-frame SHALL drop the frame without a tlast beat; the downstream consumer resynchronises on the next frame.

Configuration
REQ-028 With GMII_RX_FCS_CHECK_EN defined: a CRC-32 register (reflected polynomial 0xEDB88320, init 0xFFFFFFFF) SHALL run over all post-SFD bytes including FCS.
REQ-029 With GMII_RX_FCS_CHECK_EN defined: at frame end a register value ≠ 0xDEBB20E3 SHALL set tuser and pulse error_bad_fcs.
REQ-030 Without GMII_RX_FCS_CHECK_EN: no CRC logic; error_bad_fcs SHALL be tied to 0; FCS is still stripped.

Structure
REQ-031 Shared package eth_gmii_pkg SHALL hold the state enum, PREAMBLE=0x55, SFD=0xD5, CRC_POLY and CRC_RESIDUE constants.
REQ-032 A sub-module crc32_byte (combinational: 8-bit data plus 32-bit state in, 32-bit next state out) SHALL be used, instantiated only under the macro.

Verification
REQ-033 Scenario 1: 7×0x55, 0xD5, 64-byte frame with valid FCS -> 60 beats, tlast on byte 59, tuser=0, no error pulses.
REQ-034 Scenario 2: same frame with one payload bit flipped -> 60 beats, tuser=1, error_bad_fcs=1 on tlast (macro on); tuser=0 with macro off.
REQ-035 Scenario 3: rx_er=1 on payload byte 10 -> tuser=1 and error_bad_frame=1 on tlast.
REQ-036 Scenario 4: 1600-byte frame, MAX_LEN=1518 -> tlast after beat 1514, tuser=1, remaining bytes discarded.
REQ-037 Scenario 5: SFD followed by 3 bytes -> zero beats and one error_bad_frame pulse; a preamble with 0x12 -> zero beats, no pulse.
REQ-038 Scenario 6: rst asserted at payload byte 20, then a good frame -> no tlast for the first frame, second frame received correctly.
